uart_trx_param: RTL and testbench

Parametrised serial transceiver: one UART-style transmitter and one receiver in a single block, with a shared clock, an asynchronous reset and an optional internal loopback. It generalises the fixed 8-bit transmit/receive pair with configurable data width, bit period and parity. It adds start-of-frame validation, framing and parity error flags, and a busy/done handshake on the transmit side. The block sits between the board-level serial pins and the lab's parallel data path, and replaces the fixed-width transmitter/receiver pair in the top level.

---
 rtl/uart_trx_param.sv | 217 +++++++++++++++++++++
 tb/tb_uart_trx_param.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_trx_param.sv
// Parametrised UART transceiver: one transmitter and one receiver sharing a clock,
// with configurable width, bit period and parity, plus an internal loopback path.
module uart_trx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_start,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx,
  input  logic              rx,
  input  logic              loopback,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_parity_err,
  output logic              rx_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} txState_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAITHI} rxState_t;

  txState_t          txState_q, txState_d;
  logic [CNT_W-1:0]  txCnt_q, txCnt_d;
  logic [BIT_W-1:0]  txBit_q, txBit_d;
  logic [DATA_W-1:0] txShift_q, txShift_d;
  logic              txPar_q, txPar_d;
  logic              txLine_q, txLine_d;
  logic              txCntLast;

  rxState_t          rxState_q, rxState_d;
  logic [CNT_W-1:0]  rxCnt_q, rxCnt_d;
  logic [BIT_W-1:0]  rxBit_q, rxBit_d;
  logic [DATA_W-1:0] rxShift_q, rxShift_d;
  logic              rxPar_q, rxPar_d;
  logic [DATA_W-1:0] rxData_q, rxData_d;
  logic              rxValid_q, rxValid_d;
  logic              rxParErr_q, rxParErr_d;
  logic              rxFrameErr_q, rxFrameErr_d;
  logic [1:0]        rxSync_q;
  logic              rxPrev_q;
  logic              rxSrc, rxIn;

  assign txCntLast = (txCnt_q == CNT_LAST);

  always_comb begin
    txState_d = txState_q;
    txCnt_d   = (txState_q == T_IDLE || txCntLast) ? '0 : txCnt_q + 1'b1;
    txBit_d   = txBit_q;
    txShift_d = txShift_q;
    txPar_d   = txPar_q;
    txLine_d  = 1'b1;
    tx_done   = 1'b0;
    case (txState_q)
      T_IDLE: begin
        if (tx_start) begin
          txShift_d = tx_data;
          txPar_d   = ^tx_data ^ PARITY_ODD;
          txState_d = T_START;
        end
      end
      T_START: begin
        if (txCntLast) begin
          txBit_d   = '0;
          txState_d = T_DATA;
        end
      end
      T_DATA: begin
        if (txCntLast) begin
          txShift_d = txShift_q >> 1;
          if (txBit_q == BIT_LAST) txState_d = PARITY_EN ? T_PAR : T_STOP;
          else                     txBit_d   = txBit_q + 1'b1;
        end
      end
      T_PAR: begin
        if (txCntLast) txState_d = T_STOP;
      end
      T_STOP: begin
        if (txCntLast) begin
          tx_done   = 1'b1;
          txState_d = T_IDLE;
        end
      end
      default: txState_d = T_IDLE;
    endcase
    // The line level is registered from the next state so tx never glitches.
    case (txState_d)
      T_START: txLine_d = 1'b0;
      T_DATA:  txLine_d = txShift_d[0];
      T_PAR:   txLine_d = txPar_d;
      default: txLine_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txState_q <= T_IDLE;
      txCnt_q   <= '0;
      txBit_q   <= '0;
      txShift_q <= '0;
      txPar_q   <= 1'b0;
      txLine_q  <= 1'b1;
    end else begin
      txState_q <= txState_d;
      txCnt_q   <= txCnt_d;
      txBit_q   <= txBit_d;
      txShift_q <= txShift_d;
      txPar_q   <= txPar_d;
      txLine_q  <= txLine_d;
    end
  end

  assign tx      = txLine_q;
  assign tx_busy = (txState_q != T_IDLE);
  assign rxSrc   = loopback ? txLine_q : rx;
  assign rxIn    = rxSync_q[1];

  always_comb begin
    rxState_d    = rxState_q;
    rxCnt_d      = rxCnt_q + 1'b1;
    rxBit_d      = rxBit_q;
    rxShift_d    = rxShift_q;
    rxPar_d      = rxPar_q;
    rxData_d     = rxData_q;
    rxValid_d    = 1'b0;
    rxParErr_d   = rxParErr_q;
    rxFrameErr_d = rxFrameErr_q;
    case (rxState_q)
      R_IDLE: begin
        rxCnt_d = '0;
        if (rxPrev_q && !rxIn) rxState_d = R_START;
      end
      R_START: begin
        if (rxCnt_q == CNT_HALF) begin
          rxCnt_d   = '0;
          rxBit_d   = '0;
          rxState_d = rxIn ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (rxCnt_q == CNT_LAST) begin
          rxCnt_d   = '0;
          rxShift_d = (rxShift_q >> 1) | (DATA_W'(rxIn) << (DATA_W - 1));
          if (rxBit_q == BIT_LAST) rxState_d = PARITY_EN ? R_PAR : R_STOP;
          else                     rxBit_d   = rxBit_q + 1'b1;
        end
      end
      R_PAR: begin
        if (rxCnt_q == CNT_LAST) begin
          rxCnt_d   = '0;
          rxPar_d   = rxIn;
          rxState_d = R_STOP;
        end
      end
      R_STOP: begin
        if (rxCnt_q == CNT_LAST) begin
          rxCnt_d      = '0;
          rxData_d     = rxShift_q;
          rxParErr_d   = PARITY_EN && (rxPar_q != (^rxShift_q ^ PARITY_ODD));
          rxFrameErr_d = !rxIn;
          rxValid_d    = 1'b1;
          rxState_d    = rxIn ? R_IDLE : R_WAITHI;
        end
      end
      R_WAITHI: begin
        // A held-low line after a bad stop bit must not look like a new start.
        rxCnt_d = '0;
        if (rxIn) rxState_d = R_IDLE;
      end
      default: rxState_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxSync_q     <= 2'b11;
      rxPrev_q     <= 1'b1;
      rxState_q    <= R_IDLE;
      rxCnt_q      <= '0;
      rxBit_q      <= '0;
      rxShift_q    <= '0;
      rxPar_q      <= 1'b0;
      rxData_q     <= '0;
      rxValid_q    <= 1'b0;
      rxParErr_q   <= 1'b0;
      rxFrameErr_q <= 1'b0;
    end else begin
      rxSync_q     <= {rxSync_q[0], rxSrc};
      rxPrev_q     <= rxSync_q[1];
      rxState_q    <= rxState_d;
      rxCnt_q      <= rxCnt_d;
      rxBit_q      <= rxBit_d;
      rxShift_q    <= rxShift_d;
      rxPar_q      <= rxPar_d;
      rxData_q     <= rxData_d;
      rxValid_q    <= rxValid_d;
      rxParErr_q   <= rxParErr_d;
      rxFrameErr_q <= rxFrameErr_d;
    end
  end

  assign rx_data       = rxData_q;
  assign rx_valid      = rxValid_q;
  assign rx_parity_err = rxParErr_q;
  assign rx_frame_err  = rxFrameErr_q;

endmodule

// File: tb/tb_uart_trx_param.sv
// Bench for uart_trx_param: three configurations (default loopback, 12-bit odd parity
// loopback, 8-bit even parity external) driven by tables, sequences and random frames.
module tb_uart_trx_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] txData;
  logic [2:0]  txStart, txBusy, txDone, txo, loop, rxPin, valid, perr, ferr;
  logic [7:0]  rxDataA, rxDataC;
  logic [11:0] rxDataB;
  logic        rxLine;
  int          rxSel;
  int          checks = 0;
  int          errors = 0;
  int          validCnt [3];
  int          doneCnt [3];
  logic [2:0]  validPrev = '0;
  bit          frameQ [$];

  typedef struct {
    logic [7:0] data;
    bit         parBit;
    bit         stopBit;
    bit         expPerr;
    bit         expFerr;
  } rxVec_t;
  rxVec_t vecs [7];

  always #5 clk = ~clk;

  assign rxPin[0] = (rxSel == 0) ? rxLine : 1'b1;
  assign rxPin[1] = (rxSel == 1) ? rxLine : 1'b1;
  assign rxPin[2] = (rxSel == 2) ? rxLine : 1'b1;

  uart_trx_param dutA (
    .clk(clk), .rst(rst), .tx_data(txData[7:0]), .tx_start(txStart[0]),
    .tx_busy(txBusy[0]), .tx_done(txDone[0]), .tx(txo[0]), .rx(rxPin[0]),
    .loopback(loop[0]), .rx_data(rxDataA), .rx_valid(valid[0]),
    .rx_parity_err(perr[0]), .rx_frame_err(ferr[0]));

  uart_trx_param #(.DATA_W(12), .CLKS_PER_BIT(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dutB (
    .clk(clk), .rst(rst), .tx_data(txData[11:0]), .tx_start(txStart[1]),
    .tx_busy(txBusy[1]), .tx_done(txDone[1]), .tx(txo[1]), .rx(rxPin[1]),
    .loopback(loop[1]), .rx_data(rxDataB), .rx_valid(valid[1]),
    .rx_parity_err(perr[1]), .rx_frame_err(ferr[1]));

  uart_trx_param #(.DATA_W(8), .CLKS_PER_BIT(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dutC (
    .clk(clk), .rst(rst), .tx_data(8'h00), .tx_start(txStart[2]),
    .tx_busy(txBusy[2]), .tx_done(txDone[2]), .tx(txo[2]), .rx(rxPin[2]),
    .loopback(loop[2]), .rx_data(rxDataC), .rx_valid(valid[2]),
    .rx_parity_err(perr[2]), .rx_frame_err(ferr[2]));

  // Pulse counters and the single-cycle rx_valid rule, watched on every DUT.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (txDone[i] === 1'b1) doneCnt[i]++;
      if (valid[i] === 1'b1) begin
        validCnt[i]++;
        checks++;
        if (validPrev[i] === 1'b1) begin
          errors++;
          $display("[TB] FAIL rxValidSingle dut%0d: got two consecutive valid cycles, required one", i);
        end
      end
      validPrev[i] = valid[i];
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rxDataOf(input int i);
    case (i)
      0:       return {8'h00, rxDataA};
      1:       return {4'h0, rxDataB};
      default: return {8'h00, rxDataC};
    endcase
  endfunction

  function automatic logic [15:0] widthMask(input int w);
    return 16'((32'd1 << w) - 1);
  endfunction

  // Correct parity bit from the rule: even/odd total count of ones.
  function automatic bit modelParity(input logic [15:0] d, input int w, input bit odd);
    return bit'(($countones(d & widthMask(w)) % 2) != 0) ^ odd;
  endfunction

  function automatic void buildFrame(input logic [15:0] d, input int w, input bit hasPar,
                                     input bit parBit, input bit stopBit);
    frameQ.delete();
    frameQ.push_back(1'b0);
    for (int b = 0; b < w; b++) frameQ.push_back(d[b]);
    if (hasPar) frameQ.push_back(parBit);
    frameQ.push_back(stopBit);
  endfunction

  // Send one frame through the internal loopback and compare waveform, handshake and result.
  task automatic loopFrame(input int i, input int w, input int cpb, input bit pe, input bit po,
                           input logic [15:0] d, input string tag, output logic parSeen);
    logic [15:0] dm;
    int nb, v0, cyc, waveErr, doneN, doneAt, validAt;
    dm = d & widthMask(w);
    buildFrame(dm, w, pe, modelParity(dm, w, po), 1'b1);
    nb = frameQ.size();
    v0 = validCnt[i];
    parSeen = 1'bx;
    @(negedge clk);
    txData = dm;
    txStart[i] = 1'b1;
    @(negedge clk);
    txStart[i] = 1'b0;
    cyc = 0; waveErr = 0; doneN = 0; doneAt = -1; validAt = -1;
    while (txBusy[i] === 1'b1 && cyc < 4000) begin
      if (cyc / cpb < nb && txo[i] !== frameQ[cyc / cpb]) waveErr++;
      if (cyc == (w + 1) * cpb + cpb / 2) parSeen = txo[i];
      if (txDone[i] === 1'b1) begin doneN++; doneAt = cyc; end
      if (valid[i] === 1'b1 && validAt < 0) validAt = cyc;
      cyc++;
      @(negedge clk);
    end
    checkOutput({tag, " busyCycles"}, cyc, nb * cpb);
    checkOutput({tag, " txWaveform"}, waveErr, 0);
    checkOutput({tag, " doneCount"}, doneN, 1);
    checkOutput({tag, " doneLastCycle"}, doneAt, nb * cpb - 1);
    checkOutput({tag, " validBeforeDone"}, 32'(validAt >= 0 && validAt < doneAt), 1);
    checkOutput({tag, " txIdleHigh"}, txo[i], 1'b1);
    repeat (4) @(negedge clk);
    checkOutput({tag, " validCount"}, validCnt[i] - v0, 1);
    checkOutput({tag, " rxData"}, rxDataOf(i), dm);
    checkOutput({tag, " parityErr"}, perr[i], 1'b0);
    checkOutput({tag, " frameErr"}, ferr[i], 1'b0);
  endtask

  // Drive a hand-built frame onto the external rx pin of DUT i.
  task automatic driveRx(input int i, input logic [15:0] d, input int w, input int cpb,
                         input bit hasPar, input bit parBit, input bit stopBit, input int lowHold);
    buildFrame(d, w, hasPar, parBit, stopBit);
    rxSel = i;
    foreach (frameQ[b]) begin
      rxLine = frameQ[b];
      repeat (cpb) @(negedge clk);
    end
    if (lowHold > 0) begin
      rxLine = 1'b0;
      repeat (lowHold * cpb) @(negedge clk);
    end
    rxLine = 1'b1;
    repeat (2 * cpb) @(negedge clk);
  endtask

  task automatic applyStimulus(input int i, input logic [15:0] d, input int w, input bit hasPar,
                               input bit parBit, input bit stopBit, input int lowHold,
                               input bit expPerr, input bit expFerr, input string tag);
    int v0;
    v0 = validCnt[i];
    driveRx(i, d, w, 16, hasPar, parBit, stopBit, lowHold);
    checkOutput({tag, " validCount"}, validCnt[i] - v0, 1);
    checkOutput({tag, " rxData"}, rxDataOf(i), d & widthMask(w));
    checkOutput({tag, " parityErr"}, perr[i], expPerr);
    checkOutput({tag, " frameErr"}, ferr[i], expFerr);
  endtask

  initial begin
    logic parSeen;
    logic [7:0] rd;
    bit pb, sb;
    int v0, d0;

    vecs[0] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; txData = '0; txStart = '0; loop = 3'b011; rxLine = 1'b1; rxSel = -1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset%0d tx", i), txo[i], 1'b1);
      checkOutput($sformatf("reset%0d busy", i), txBusy[i], 1'b0);
      checkOutput($sformatf("reset%0d done", i), txDone[i], 1'b0);
      checkOutput($sformatf("reset%0d rxData", i), rxDataOf(i), 16'h0000);
      checkOutput($sformatf("reset%0d valid", i), valid[i], 1'b0);
      checkOutput($sformatf("reset%0d perr", i), perr[i], 1'b0);
      checkOutput($sformatf("reset%0d ferr", i), ferr[i], 1'b0);
    end

    $display("[TB] loopback default frame");
    loopFrame(0, 8, 16, 1'b0, 1'b0, 16'h00A5, "loopA5", parSeen);

    $display("[TB] loopback 12-bit odd parity frame");
    loopFrame(1, 12, 16, 1'b1, 1'b1, 16'h03C7, "loopB3C7", parSeen);
    checkOutput("loopB3C7 parityBitOnTx", parSeen, 1'b0);

    $display("[TB] external rx table, even parity");
    for (int k = 0; k < 7; k++)
      applyStimulus(2, {8'h00, vecs[k].data}, 8, 1'b1, vecs[k].parBit, vecs[k].stopBit, 0,
                    vecs[k].expPerr, vecs[k].expFerr, $sformatf("vec%0d", k));

    $display("[TB] randomized frames");
    for (int k = 0; k < 6; k++) begin
      loopFrame(0, 8, 16, 1'b0, 1'b0, 16'($urandom), $sformatf("randA%0d", k), parSeen);
      loopFrame(1, 12, 16, 1'b1, 1'b1, 16'($urandom), $sformatf("randB%0d", k), parSeen);
      rd = 8'($urandom_range(0, 255));
      pb = bit'($urandom_range(0, 1));
      sb = ($urandom_range(0, 3) != 0);
      applyStimulus(2, {8'h00, rd}, 8, 1'b1, pb, sb, 0, pb != modelParity({8'h00, rd}, 8, 1'b0),
                    !sb, $sformatf("randC%0d", k));
    end

    $display("[TB] framing error with held-low line");
    loop[0] = 1'b0;
    applyStimulus(0, 16'h003C, 8, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b1, "heldLow");
    applyStimulus(0, 16'h00C3, 8, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, "afterHeldLow");

    $display("[TB] short low glitch");
    v0 = validCnt[0];
    rxSel = 0;
    rxLine = 1'b0;
    repeat (4) @(negedge clk);
    rxLine = 1'b1;
    repeat (32) @(negedge clk);
    checkOutput("glitch noValid", validCnt[0] - v0, 0);
    applyStimulus(0, 16'h005A, 8, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, "afterGlitch");

    $display("[TB] reset during data bits");
    rxSel = -1;
    loop[0] = 1'b1;
    v0 = validCnt[0];
    d0 = doneCnt[0];
    @(negedge clk);
    txData = 16'h0096;
    txStart[0] = 1'b1;
    @(negedge clk);
    txStart[0] = 1'b0;
    repeat (3 * 16 + 5) @(negedge clk);
    checkOutput("midFrame busy", txBusy[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncReset tx", txo[0], 1'b1);
    checkOutput("asyncReset busy", txBusy[0], 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    checkOutput("abort noDone", doneCnt[0] - d0, 0);
    checkOutput("abort noValid", validCnt[0] - v0, 0);
    loopFrame(0, 8, 16, 1'b0, 1'b0, 16'h0069, "afterReset", parSeen);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
